// File: rtl/i2c_slave_if.sv
// Host-side byte interface of the i2c_slave target: transmit/receive bytes, transfer status and FSM state.
interface i2c_slave_if;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_req;
  logic       rw;
  logic       busy;
  logic [2:0] state;

  // rx_valid and tx_req are single-clk pulses with no back-pressure.
  // The host answers tx_req by putting the next byte on tx_data and holding it
  // until the next scl falling edge, when the target loads it.
  modport slave (
    input  tx_data,
    output rx_data, rx_valid, tx_req, rw, busy, state
  );

  modport master (
    output tx_data,
    input  rx_data, rx_valid, tx_req, rw, busy, state
  );
endinterface

// File: rtl/i2c_slave.sv
// 7-bit-address I2C target with oversampled scl/sda, open-drain sda and a byte-level host interface.
// Define I2C_SLAVE_GENCALL_EN to also accept the general-call address (8'h00, write only).
module i2c_slave #(
  parameter logic [6:0] ADDR = 7'h50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl,
  inout  wire         sda,
  i2c_slave_if.slave  bus
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ADDR      = 3'd1;
  localparam logic [2:0] S_ADDR_ACK  = 3'd2;
  localparam logic [2:0] S_WRITE     = 3'd3;
  localparam logic [2:0] S_WRITE_ACK = 3'd4;
  localparam logic [2:0] S_READ      = 3'd5;
  localparam logic [2:0] S_READ_ACK  = 3'd6;
  localparam logic [2:0] S_WAIT_STOP = 3'd7;

  logic       scl_s1_q, scl_s2_q, scl_s3_q;
  logic       sda_s1_q, sda_s2_q, sda_s3_q;
  logic [2:0] state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       sda_oe_q, sda_oe_d;
  logic       ack_on_q, ack_on_d;
  logic       rw_q, rw_d;
  logic       busy_q, busy_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_req_q, tx_req_d;

  logic       scl_rise, scl_fall, bus_start, bus_stop, last_bit;
  logic [7:0] byte_in;
  logic       addr_hit, gencall_hit;

  // Synchronizers reset to 1 so an idle bus never looks like a START/STOP after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_s1_q <= 1'b1;
      scl_s2_q <= 1'b1;
      scl_s3_q <= 1'b1;
      sda_s1_q <= 1'b1;
      sda_s2_q <= 1'b1;
      sda_s3_q <= 1'b1;
    end else begin
      scl_s1_q <= scl;
      scl_s2_q <= scl_s1_q;
      scl_s3_q <= scl_s2_q;
      sda_s1_q <= sda;
      sda_s2_q <= sda_s1_q;
      sda_s3_q <= sda_s2_q;
    end
  end

  assign scl_rise  = scl_s2_q & ~scl_s3_q;
  assign scl_fall  = ~scl_s2_q & scl_s3_q;
  assign bus_start = scl_s2_q & scl_s3_q & sda_s3_q & ~sda_s2_q;
  assign bus_stop  = scl_s2_q & scl_s3_q & ~sda_s3_q & sda_s2_q;
  assign last_bit  = (bit_cnt_q == 3'd7);
  assign byte_in   = {shift_q[6:0], sda_s2_q};
  assign addr_hit  = (byte_in[7:1] == ADDR);

`ifdef I2C_SLAVE_GENCALL_EN
  assign gencall_hit = (byte_in == 8'h00);
`else
  assign gencall_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus_stop) begin
      state_d = S_IDLE;
    end else if (bus_start) begin
      state_d = S_ADDR;
    end else begin
      case (state_q)
        S_ADDR: begin
          if (scl_rise && last_bit)
            state_d = (addr_hit || gencall_hit) ? S_ADDR_ACK : S_WAIT_STOP;
        end
        S_ADDR_ACK: begin
          if (scl_fall && ack_on_q) state_d = rw_q ? S_READ : S_WRITE;
        end
        S_WRITE: begin
          if (scl_rise && last_bit) state_d = S_WRITE_ACK;
        end
        S_WRITE_ACK: begin
          if (scl_fall && ack_on_q) state_d = S_WRITE;
        end
        S_READ: begin
          if (scl_fall && last_bit) state_d = S_READ_ACK;
        end
        S_READ_ACK: begin
          if (scl_rise && sda_s2_q)       state_d = S_WAIT_STOP;
          else if (scl_fall && ack_on_q)  state_d = S_READ;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // ack_on_q marks the second half of an ACK slot: our ACK is driven (ADDR_ACK/WRITE_ACK)
  // or the master has ACKed and the next byte is due (READ_ACK).
  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    sda_oe_d   = sda_oe_q;
    ack_on_d   = ack_on_q;
    rw_d       = rw_q;
    busy_d     = busy_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    if (bus_stop) begin
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      ack_on_d  = 1'b0;
      bit_cnt_d = 3'd0;
    end else if (bus_start) begin
      sda_oe_d  = 1'b0;
      ack_on_d  = 1'b0;
      bit_cnt_d = 3'd0;
    end else begin
      case (state_q)
        S_ADDR: begin
          sda_oe_d = 1'b0;
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (last_bit) begin
              ack_on_d = 1'b0;
              if (addr_hit || gencall_hit) begin
                rw_d   = byte_in[0];
                busy_d = 1'b1;
              end else begin
                busy_d = 1'b0;
              end
            end
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall) begin
            if (!ack_on_q) begin
              sda_oe_d = 1'b1;
              ack_on_d = 1'b1;
              tx_req_d = rw_q;
            end else begin
              ack_on_d  = 1'b0;
              bit_cnt_d = 3'd0;
              if (rw_q) begin
                shift_d  = bus.tx_data;
                sda_oe_d = ~bus.tx_data[7];
              end else begin
                sda_oe_d = 1'b0;
              end
            end
          end
        end
        S_WRITE: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (last_bit) begin
              rx_data_d  = byte_in;
              rx_valid_d = 1'b1;
              ack_on_d   = 1'b0;
            end
          end
        end
        S_WRITE_ACK: begin
          if (scl_fall) begin
            sda_oe_d  = ~ack_on_q;
            ack_on_d  = ~ack_on_q;
            bit_cnt_d = 3'd0;
          end
        end
        S_READ: begin
          if (scl_fall) begin
            if (last_bit) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 3'd0;
              ack_on_d  = 1'b0;
            end else begin
              shift_d   = {shift_q[6:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 3'd1;
              sda_oe_d  = ~shift_q[6];
            end
          end
        end
        S_READ_ACK: begin
          if (scl_rise && !sda_s2_q) begin
            tx_req_d = 1'b1;
            ack_on_d = 1'b1;
          end else if (scl_fall && ack_on_q) begin
            shift_d   = bus.tx_data;
            sda_oe_d  = ~bus.tx_data[7];
            bit_cnt_d = 3'd0;
            ack_on_d  = 1'b0;
          end
        end
        default: sda_oe_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      sda_oe_q   <= 1'b0;
      ack_on_q   <= 1'b0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      sda_oe_q   <= sda_oe_d;
      ack_on_q   <= ack_on_d;
      rw_q       <= rw_d;
      busy_q     <= busy_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
    end
  end

  assign sda          = sda_oe_q ? 1'b0 : 1'bz;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.tx_req   = tx_req_q;
  assign bus.rw       = rw_q;
  assign bus.busy     = busy_q;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: a bus master model drives scl/sda, a host model answers tx_req.
`timescale 1ns/1ps
module tb_i2c_slave;

  localparam int Q = 40;  // quarter scl period: 4 clk
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WAIT_STOP = 3'd7;

  logic clk;
  logic rst;
  logic scl;
  logic m_sda_low;
  wire  sda;

  pullup (sda);
  assign sda = m_sda_low ? 1'b0 : 1'bz;

  i2c_slave_if bus ();

  i2c_slave #(.ADDR(7'h50)) dut (
    .clk (clk),
    .rst (rst),
    .scl (scl),
    .sda (sda),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_rxv = 0;
  int n_txr = 0;
  int n_dut_low = 0;
  int n_busy_hi = 0;
  logic [7:0] tx_list [8];

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // pulse and drive monitors, sampled on the falling clk edge
  initial begin
    forever begin
      @(negedge clk);
      if (bus.rx_valid) n_rxv++;
      if (bus.busy) n_busy_hi++;
      if (!m_sda_low && !sda) n_dut_low++;
    end
  end

  // host: answer each tx_req with the next queued byte
  initial begin
    bus.tx_data = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.tx_req) begin
        bus.tx_data = tx_list[n_txr % 8];
        n_txr++;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // bus master driver tasks; each bit task starts and ends with scl low
  task automatic bus_start();
    m_sda_low = 1'b1; #Q;
    scl = 1'b0;       #Q;
  endtask

  task automatic bus_rstart();
    m_sda_low = 1'b0; #Q;
    scl = 1'b1;       #Q;
    m_sda_low = 1'b1; #Q;
    scl = 1'b0;       #Q;
  endtask

  task automatic bus_stop();
    m_sda_low = 1'b1; #Q;
    scl = 1'b1;       #Q;
    m_sda_low = 1'b0; #Q;
  endtask

  task automatic write_bit(input logic b);
    m_sda_low = ~b; #Q;
    scl = 1'b1;     #(2*Q);
    scl = 1'b0;     #Q;
  endtask

  task automatic read_bit(output logic b);
    m_sda_low = 1'b0; #Q;
    scl = 1'b1;       #Q;
    b = sda;          #Q;
    scl = 1'b0;       #Q;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(ack);
  endtask

  initial begin
    logic       ack;
    logic [7:0] rd;
    int         rxv0, txr0, low0, busy0, k;

    for (int i = 0; i < 8; i++) tx_list[i] = 8'h00;
    scl = 1'b1;
    m_sda_low = 1'b0;
    rst = 1'b0;

    // reset held while the bus toggles
    rxv0 = n_rxv; txr0 = n_txr;
    #20;
    bus_start();
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1);
    bus_stop();
    m_sda_low = 1'b0;
    #Q;
    check_eq("rst_sda", 32'(sda), 32'd1);
    check_eq("rst_rx_data", 32'(bus.rx_data), 32'h00);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_state", 32'(bus.state), 32'(ST_IDLE));
    check_eq("rst_rx_valid_pulses", 32'(n_rxv - rxv0), 32'd0);
    check_eq("rst_tx_req_pulses", 32'(n_txr - txr0), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #(10*Q);
    check_eq("post_rst_idle", 32'(bus.state), 32'(ST_IDLE));

    // write 0x55 to 0x50
    rxv0 = n_rxv;
    bus_start();
    write_byte(8'hA0, ack);
    check_eq("wr_addr_ack", 32'(ack), 32'd0);
    check_eq("wr_busy", 32'(bus.busy), 32'd1);
    write_byte(8'h55, ack);
    check_eq("wr_data_ack", 32'(ack), 32'd0);
    check_eq("wr_rx_valid_pulses", 32'(n_rxv - rxv0), 32'd1);
    check_eq("wr_rx_data", 32'(bus.rx_data), 32'h55);
    check_eq("wr_rw", 32'(bus.rw), 32'd0);
    bus_stop();
    #Q;
    check_eq("wr_busy_after_stop", 32'(bus.busy), 32'd0);
    check_eq("wr_state_after_stop", 32'(bus.state), 32'(ST_IDLE));

    // read two bytes, ACK then NACK
    k = n_txr;
    tx_list[k % 8] = 8'hA5;
    tx_list[(k + 1) % 8] = 8'h3C;
    txr0 = n_txr;
    bus_start();
    write_byte(8'hA1, ack);
    check_eq("rd_addr_ack", 32'(ack), 32'd0);
    check_eq("rd_rw", 32'(bus.rw), 32'd1);
    read_byte(1'b0, rd);
    check_eq("rd_byte0", 32'(rd), 32'hA5);
    read_byte(1'b1, rd);
    check_eq("rd_byte1", 32'(rd), 32'h3C);
    check_eq("rd_tx_req_pulses", 32'(n_txr - txr0), 32'd2);
    check_eq("rd_sda_released", 32'(sda), 32'd1);
    check_eq("rd_wait_stop", 32'(bus.state), 32'(ST_WAIT_STOP));
    bus_stop();
    #Q;
    check_eq("rd_busy_after_stop", 32'(bus.busy), 32'd0);

    // address mismatch
    rxv0 = n_rxv; low0 = n_dut_low; busy0 = n_busy_hi;
    bus_start();
    write_byte(8'hA2, ack);
    check_eq("mm_addr_nack", 32'(ack), 32'd1);
    write_byte(8'hFF, ack);
    check_eq("mm_data_nack", 32'(ack), 32'd1);
    bus_stop();
    #Q;
    check_eq("mm_sda_never_driven", 32'(n_dut_low - low0), 32'd0);
    check_eq("mm_rx_valid_pulses", 32'(n_rxv - rxv0), 32'd0);
    check_eq("mm_busy_never_high", 32'(n_busy_hi - busy0), 32'd0);

    // write, repeated START, read one byte
    k = n_txr;
    tx_list[k % 8] = 8'hC3;
    txr0 = n_txr; rxv0 = n_rxv;
    bus_start();
    write_byte(8'hA0, ack);
    check_eq("sr_wr_addr_ack", 32'(ack), 32'd0);
    write_byte(8'h12, ack);
    check_eq("sr_wr_data_ack", 32'(ack), 32'd0);
    bus_rstart();
    write_byte(8'hA1, ack);
    check_eq("sr_rd_addr_ack", 32'(ack), 32'd0);
    check_eq("sr_rx_data", 32'(bus.rx_data), 32'h12);
    check_eq("sr_rw", 32'(bus.rw), 32'd1);
    read_byte(1'b1, rd);
    check_eq("sr_rd_byte", 32'(rd), 32'hC3);
    bus_stop();
    #Q;
    check_eq("sr_tx_req_pulses", 32'(n_txr - txr0), 32'd1);
    check_eq("sr_rx_valid_pulses", 32'(n_rxv - rxv0), 32'd1);
    check_eq("sr_state_after_stop", 32'(bus.state), 32'(ST_IDLE));

    // STOP in the middle of a write data byte
    rxv0 = n_rxv;
    bus_start();
    write_byte(8'hA0, ack);
    check_eq("mid_addr_ack", 32'(ack), 32'd0);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
    bus_stop();
    #Q;
    check_eq("mid_state", 32'(bus.state), 32'(ST_IDLE));
    check_eq("mid_rx_valid_pulses", 32'(n_rxv - rxv0), 32'd0);
    check_eq("mid_busy", 32'(bus.busy), 32'd0);
    check_eq("mid_rx_data_held", 32'(bus.rx_data), 32'h12);

    // reset pulse while the target drives a read 0 bit
    k = n_txr;
    tx_list[k % 8] = 8'h00;
    bus_start();
    write_byte(8'hA1, ack);
    check_eq("rr_addr_ack", 32'(ack), 32'd0);
    #Q;
    check_eq("rr_sda_driven", 32'(sda), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rr_sda_released", 32'(sda), 32'd1);
    check_eq("rr_state", 32'(bus.state), 32'(ST_IDLE));
    #20;
    rst = 1'b1;
    scl = 1'b1;
    #(4*Q);
    check_eq("rr_state_after", 32'(bus.state), 32'(ST_IDLE));
    check_eq("rr_busy_after", 32'(bus.busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
